// File: rtl/mpu_target_pkg.sv
// Shared types and register-map constants for the MPU-6050 I2C target model.
package mpu_target_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrPtr,
        StWrData,
        StWrAck,
        StRdData,
        StRdMack
    } state_e;

    localparam logic [7:0] REG_GYRO_XH    = 8'h43;
    localparam logic [7:0] REG_GYRO_XL    = 8'h44;
    localparam logic [7:0] REG_GYRO_YH    = 8'h45;
    localparam logic [7:0] REG_GYRO_YL    = 8'h46;
    localparam logic [7:0] REG_GYRO_ZH    = 8'h47;
    localparam logic [7:0] REG_GYRO_ZL    = 8'h48;
    localparam logic [7:0] REG_PWR_MGMT_1 = 8'h6B;
    localparam logic [7:0] REG_WHO_AM_I   = 8'h75;

    localparam logic [7:0] PWR_MGMT_1_RST = 8'h40;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer and START/STOP/edge detector.
// Optional MPU_TARGET_GLITCH_FILTER_EN inserts a 3-sample majority filter per line.
module i2c_line_sync (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise_out,
    output logic scl_fall_out,
    output logic start_out,
    output logic stop_out,
    output logic sda_out
);

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_s, sda_s;

    // Idle bus is high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
        end
    end

`ifdef MPU_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_filt_q, sda_filt_q;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_filt_q <= maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
            sda_filt_q <= maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
        end
    end

    assign scl_s = scl_filt_q;
    assign sda_s = sda_filt_q;
`else
    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];
`endif

    logic scl_p_q, sda_p_q;
    logic scl_rise_q, scl_fall_q, start_q, stop_q, sda_q;

    // START/STOP qualify on the new SCL level, so a coincident SCL fall wins over the SDA edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_q      <= 1'b1;
        end else begin
            scl_p_q    <= scl_s;
            sda_p_q    <= sda_s;
            scl_rise_q <= scl_s & ~scl_p_q;
            scl_fall_q <= ~scl_s & scl_p_q;
            start_q    <= ~sda_s & sda_p_q & scl_s;
            stop_q     <= sda_s & ~sda_p_q & scl_s;
            sda_q      <= sda_s;
        end
    end

    assign scl_rise_out = scl_rise_q;
    assign scl_fall_out = scl_fall_q;
    assign start_out    = start_q;
    assign stop_out     = stop_q;
    assign sda_out      = sda_q;

endmodule

// File: rtl/mpu_i2c_target.sv
// MPU-6050 I2C target model: address/pointer/data decode and small register map.
// Build option MPU_TARGET_GLITCH_FILTER_EN enables the line glitch filter.
module mpu_i2c_target
    import mpu_target_pkg::*;
#(
    parameter logic [6:0]  ADDR         = 7'h68,
    parameter logic [7:0]  WHO_AM_I_VAL = 8'h68,
    parameter int unsigned HOLD_CYCLES  = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe_out,
    input  logic [15:0] gx_in,
    input  logic [15:0] gy_in,
    input  logic [15:0] gz_in,
    output logic [7:0]  pwr_mgmt_out,
    output logic        wr_strobe_out,
    output logic        busy_out
);

    localparam logic [3:0] HoldInit = 4'(HOLD_CYCLES - 1);

    logic scl_rise, scl_fall, start, stop, sda;

    i2c_line_sync u_line_sync (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .scl_in       (scl_in),
        .sda_in       (sda_in),
        .scl_rise_out (scl_rise),
        .scl_fall_out (scl_fall),
        .start_out    (start),
        .stop_out     (stop),
        .sda_out      (sda)
    );

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ack_ph_q, ack_ph_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        mack_q, mack_d;
    logic        busy_q, busy_d;
    logic [7:0]  pwr_q, pwr_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [47:0] snap_q, snap_d;
    logic        sda_oe_q, sda_oe_d;
    logic        pend_q, pend_d;
    logic [3:0]  hold_q, hold_d;

    logic        sched, sched_val, release_now;
    logic [7:0]  byte_in, rd_cur;

    function automatic logic [7:0] rd_byte(input logic [7:0] a, input logic [47:0] s,
                                           input logic [7:0] pwr);
        case (a)
            REG_GYRO_XH:    return s[47:40];
            REG_GYRO_XL:    return s[39:32];
            REG_GYRO_YH:    return s[31:24];
            REG_GYRO_YL:    return s[23:16];
            REG_GYRO_ZH:    return s[15:8];
            REG_GYRO_ZL:    return s[7:0];
            REG_PWR_MGMT_1: return pwr;
            REG_WHO_AM_I:   return WHO_AM_I_VAL;
            default:        return 8'h00;
        endcase
    endfunction

    assign byte_in = {shift_q[6:0], sda};
    assign rd_cur  = rd_byte(ptr_q, snap_q, pwr_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ack_ph_d    = ack_ph_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        mack_d      = mack_q;
        busy_d      = busy_q;
        pwr_d       = pwr_q;
        wr_strobe_d = 1'b0;
        snap_d      = snap_q;
        sda_oe_d    = sda_oe_q;
        pend_d      = pend_q;
        hold_d      = hold_q;
        sched       = 1'b0;
        sched_val   = 1'b0;
        release_now = 1'b0;

        if (hold_q != 4'd0) begin
            hold_d = hold_q - 4'd1;
            if (hold_q == 4'd1) sda_oe_d = pend_q;
        end

        if (stop) begin
            state_d     = StIdle;
            busy_d      = 1'b0;
            release_now = 1'b1;
        end else if (start) begin
            state_d     = StAddr;
            cnt_d       = 3'd7;
            release_now = 1'b1;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        if (cnt_q == 3'd0) begin
                            if (byte_in[7:1] == ADDR) begin
                                state_d  = StAddrAck;
                                ack_ph_d = 1'b0;
                                rw_d     = byte_in[0];
                                busy_d   = 1'b1;
                                if (byte_in[0]) snap_d = {gx_in, gy_in, gz_in};
                            end else begin
                                state_d = StIdle;
                            end
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                // First fall after the byte drives ACK, the second (9th) ends the ACK slot.
                StAddrAck, StWrAck: begin
                    if (scl_fall) begin
                        sched = 1'b1;
                        if (!ack_ph_q) begin
                            ack_ph_d  = 1'b1;
                            sched_val = 1'b1;
                        end else begin
                            cnt_d = 3'd7;
                            if (state_q == StAddrAck && rw_q) begin
                                state_d   = StRdData;
                                tx_d      = rd_cur;
                                sched_val = ~rd_cur[7];
                            end else begin
                                state_d   = (state_q == StAddrAck) ? StWrPtr : StWrData;
                                sched_val = 1'b0;
                            end
                        end
                    end
                end
                StWrPtr: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        if (cnt_q == 3'd0) begin
                            ptr_d    = byte_in;
                            state_d  = StWrAck;
                            ack_ph_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                StWrData: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        if (cnt_q == 3'd0) begin
                            wr_strobe_d = 1'b1;
                            if (ptr_q == REG_PWR_MGMT_1) pwr_d = byte_in;
                            ptr_d    = ptr_q + 8'd1;
                            state_d  = StWrAck;
                            ack_ph_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                StRdData: begin
                    if (scl_rise) begin
                        if (cnt_q == 3'd0) begin
                            state_d  = StRdMack;
                            ack_ph_d = 1'b0;
                            ptr_d    = ptr_q + 8'd1;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                            tx_d  = {tx_q[6:0], 1'b0};
                        end
                    end else if (scl_fall) begin
                        sched     = 1'b1;
                        sched_val = ~tx_q[7];
                    end
                end
                StRdMack: begin
                    if (scl_rise) begin
                        mack_d = sda;
                    end else if (scl_fall) begin
                        if (!ack_ph_q) begin
                            ack_ph_d  = 1'b1;
                            sched     = 1'b1;
                            sched_val = 1'b0;
                        end else if (!mack_q) begin
                            state_d   = StRdData;
                            cnt_d     = 3'd7;
                            tx_d      = rd_cur;
                            sched     = 1'b1;
                            sched_val = ~rd_cur[7];
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (sched) begin
            if (HOLD_CYCLES == 1) begin
                sda_oe_d = sched_val;
                hold_d   = 4'd0;
            end else begin
                pend_d = sched_val;
                hold_d = HoldInit;
            end
        end
        if (release_now) begin
            sda_oe_d = 1'b0;
            hold_d   = 4'd0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd7;
            ack_ph_q    <= 1'b0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            ptr_q       <= 8'h00;
            rw_q        <= 1'b0;
            mack_q      <= 1'b1;
            busy_q      <= 1'b0;
            pwr_q       <= PWR_MGMT_1_RST;
            wr_strobe_q <= 1'b0;
            snap_q      <= 48'h0;
            sda_oe_q    <= 1'b0;
            pend_q      <= 1'b0;
            hold_q      <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ack_ph_q    <= ack_ph_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            mack_q      <= mack_d;
            busy_q      <= busy_d;
            pwr_q       <= pwr_d;
            wr_strobe_q <= wr_strobe_d;
            snap_q      <= snap_d;
            sda_oe_q    <= sda_oe_d;
            pend_q      <= pend_d;
            hold_q      <= hold_d;
        end
    end

    assign sda_oe_out    = sda_oe_q;
    assign pwr_mgmt_out  = pwr_q;
    assign wr_strobe_out = wr_strobe_q;
    assign busy_out      = busy_q;

endmodule

// File: tb/tb_mpu_i2c_target.sv
// Directed bench for mpu_i2c_target: a bit-banged I2C master on an open-drain SDA model.
module tb_mpu_i2c_target;

    localparam int Q   = 12;     // quarter SCL period in clk cycles
    localparam int Lat = 3 + 4;  // pin SCL fall to SDA drive change (sync + edge + HOLD_CYCLES)

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl_m, sda_m;
    logic        sda_bus;
    logic        sda_oe;
    logic [15:0] gx, gy, gz;
    logic [7:0]  pwr;
    logic        wr_strobe, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    int oe_cnt = 0;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;

    mpu_i2c_target #(
        .ADDR         (7'h68),
        .WHO_AM_I_VAL (8'h68),
        .HOLD_CYCLES  (4)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .scl_in        (scl_m),
        .sda_in        (sda_bus),
        .sda_oe_out    (sda_oe),
        .gx_in         (gx),
        .gy_in         (gy),
        .gz_in         (gz),
        .pwr_mgmt_out  (pwr),
        .wr_strobe_out (wr_strobe),
        .busy_out      (busy)
    );

    always @(negedge clk) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic i2c_start();
        repeat (Q) @(negedge clk);
        sda_m = 1'b0;
        repeat (Q) @(negedge clk);
        scl_m = 1'b0;
    endtask

    task automatic i2c_rstart();
        repeat (Q) @(negedge clk);
        sda_m = 1'b1;
        repeat (Q) @(negedge clk);
        scl_m = 1'b1;
        repeat (Q) @(negedge clk);
        sda_m = 1'b0;
        repeat (Q) @(negedge clk);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        repeat (Q) @(negedge clk);
        sda_m = 1'b0;
        repeat (Q) @(negedge clk);
        scl_m = 1'b1;
        repeat (Q) @(negedge clk);
        sda_m = 1'b1;
        repeat (2 * Q) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        repeat (Q) @(negedge clk);
        sda_m = b;
        repeat (Q) @(negedge clk);
        scl_m = 1'b1;
        repeat (2 * Q) @(negedge clk);
        scl_m = 1'b0;
    endtask

    // chk: also verify exact ACK drive/release timing relative to the SCL falls.
    task automatic send_byte(input logic [7:0] b, input bit chk, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        for (int i = 1; i <= Q; i++) begin
            @(negedge clk);
            if (chk && i == Lat - 1) check("ack_drive_early", 16'(sda_oe), 16'h0);
            if (chk && i == Lat) check("ack_drive_on_time", 16'(sda_oe), 16'h1);
        end
        sda_m = 1'b1;
        repeat (Q) @(negedge clk);
        scl_m = 1'b1;
        repeat (Q) @(negedge clk);
        ack = sda_oe;
        repeat (Q) @(negedge clk);
        scl_m = 1'b0;
        if (chk) begin
            for (int i = 1; i <= Lat; i++) begin
                @(negedge clk);
                if (i == Lat - 1) check("ack_release_early", 16'(sda_oe), 16'h1);
                if (i == Lat) check("ack_release_on_time", 16'(sda_oe), 16'h0);
            end
        end
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            repeat (Q) @(negedge clk);
            sda_m = 1'b1;
            repeat (Q) @(negedge clk);
            scl_m = 1'b1;
            repeat (Q) @(negedge clk);
            b[i] = sda_bus;
            repeat (Q) @(negedge clk);
            scl_m = 1'b0;
        end
        repeat (Q) @(negedge clk);
        sda_m = nack;
        repeat (Q) @(negedge clk);
        scl_m = 1'b1;
        repeat (2 * Q) @(negedge clk);
        scl_m = 1'b0;
    endtask

    // Addressed write of a pointer byte plus n data bytes, all expected ACKed.
    task automatic wr_seq(input string tag, input logic [7:0] p, input logic [7:0] d0,
                          input logic [7:0] d1, input int n);
        logic ack;
        i2c_start();
        send_byte(8'hD0, 1'b0, ack);
        check({tag, "_ack_addr"}, 16'(ack), 16'h1);
        send_byte(p, 1'b0, ack);
        check({tag, "_ack_ptr"}, 16'(ack), 16'h1);
        if (n > 0) begin
            send_byte(d0, 1'b0, ack);
            check({tag, "_ack_d0"}, 16'(ack), 16'h1);
        end
        if (n > 1) begin
            send_byte(d1, 1'b0, ack);
            check({tag, "_ack_d1"}, 16'(ack), 16'h1);
        end
        i2c_stop();
    endtask

    task automatic set_ptr_rstart_read(input string tag, input logic [7:0] p);
        logic ack;
        i2c_start();
        send_byte(8'hD0, 1'b0, ack);
        check({tag, "_ack_waddr"}, 16'(ack), 16'h1);
        send_byte(p, 1'b0, ack);
        check({tag, "_ack_ptr"}, 16'(ack), 16'h1);
        i2c_rstart();
        send_byte(8'hD1, 1'b0, ack);
        check({tag, "_ack_raddr"}, 16'(ack), 16'h1);
    endtask

    initial begin
        #600us;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] rb;
        logic [7:0] exp_burst [6];
        int         s0, o0;

        rst_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        gx    = 16'h0;
        gy    = 16'h0;
        gz    = 16'h0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        check("rst_sda_oe", 16'(sda_oe), 16'h0);
        check("rst_pwr", 16'(pwr), 16'h0040);
        check("rst_strobe", 16'(wr_strobe), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);

        // Write PWR_MGMT_1 = 0x00 with exact ACK timing checks.
        i2c_start();
        send_byte(8'hD0, 1'b1, ack);
        check("t1_ack_addr", 16'(ack), 16'h1);
        check("t1_busy_mid", 16'(busy), 16'h1);
        send_byte(8'h6B, 1'b0, ack);
        check("t1_ack_ptr", 16'(ack), 16'h1);
        s0 = strobe_cnt;
        send_byte(8'h00, 1'b1, ack);
        check("t1_ack_data", 16'(ack), 16'h1);
        i2c_stop();
        check("t1_strobe_count", 16'(strobe_cnt - s0), 16'h1);
        check("t1_pwr", 16'(pwr), 16'h0000);
        check("t1_busy_after_stop", 16'(busy), 16'h0);

        // WHO_AM_I via repeated START and single NACKed read.
        set_ptr_rstart_read("t2", 8'h75);
        read_byte(1'b1, rb);
        check("t2_whoami", 16'(rb), 16'h0068);
        check("t2_busy_before_stop", 16'(busy), 16'h1);
        i2c_stop();
        check("t2_busy_after_stop", 16'(busy), 16'h0);

        // Six-byte gyro burst; gx changes mid-burst but the snapshot must hold.
        gx = 16'h1234;
        gy = 16'h8001;
        gz = 16'hFFFF;
        exp_burst = '{8'h12, 8'h34, 8'h80, 8'h01, 8'hFF, 8'hFF};
        set_ptr_rstart_read("t3", 8'h43);
        for (int i = 0; i < 6; i++) begin
            read_byte((i == 5), rb);
            check($sformatf("t3_burst_%0d", i), 16'(rb), 16'(exp_burst[i]));
            if (i == 0) gx = 16'hAAAA;
        end
        i2c_stop();

        // Foreign address is ignored entirely.
        o0 = oe_cnt;
        i2c_start();
        send_byte(8'hA0, 1'b0, ack);
        check("t4_no_ack", 16'(ack), 16'h0);
        check("t4_busy", 16'(busy), 16'h0);
        i2c_stop();
        check("t4_never_drove", 16'(oe_cnt - o0), 16'h0);
        check("t4_busy_end", 16'(busy), 16'h0);

        // Pointer wrap from 0xFF.
        set_ptr_rstart_read("t5", 8'hFF);
        read_byte(1'b0, rb);
        check("t5_rd_ff", 16'(rb), 16'h0000);
        read_byte(1'b1, rb);
        check("t5_rd_00", 16'(rb), 16'h0000);
        i2c_stop();
        check("t5_busy_end", 16'(busy), 16'h0);

        // Writes outside 0x6B are ACKed and dropped; pointer auto-increments into 0x6B.
        s0 = strobe_cnt;
        wr_seq("t6a", 8'h75, 8'h55, 8'h00, 1);
        check("t6a_strobe", 16'(strobe_cnt - s0), 16'h1);
        check("t6a_pwr_kept", 16'(pwr), 16'h0000);
        set_ptr_rstart_read("t6b", 8'h75);
        read_byte(1'b1, rb);
        check("t6b_whoami_kept", 16'(rb), 16'h0068);
        i2c_stop();
        s0 = strobe_cnt;
        wr_seq("t6c", 8'h6A, 8'hAA, 8'hBB, 2);
        check("t6c_strobe", 16'(strobe_cnt - s0), 16'h2);
        check("t6c_pwr", 16'(pwr), 16'h00BB);

        // Reset while the target drives bit7=0 of WHO_AM_I.
        set_ptr_rstart_read("t7", 8'h75);
        repeat (Lat + 1) @(negedge clk);
        check("t7_driving_zero", 16'(sda_oe), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_release", 16'(sda_oe), 16'h0);
        repeat (3) @(negedge clk);
        sda_m = 1'b1;
        scl_m = 1'b1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t7_pwr_reset", 16'(pwr), 16'h0040);
        check("t7_busy_reset", 16'(busy), 16'h0);
        wr_seq("t7_clean", 8'h6B, 8'h01, 8'h00, 1);
        check("t7_clean_pwr", 16'(pwr), 16'h0001);
        check("t7_clean_busy", 16'(busy), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mpu_i2c_target.md
# mpu_i2c_target

I2C target (responder) model of the MPU-6050 gyroscope, the far end of the I2C master that polls gyro data. It decodes START/STOP, address, register-pointer and data bytes on an open-drain bus sampled in the FPGA clock domain, and serves a small register map. Gyro registers are fed from fabric inputs, so the master path can run in loopback on the board and in simulation without the physical sensor.

## Interface
- ADDR, 7'h68: 7-bit target address; any other address is NACKed and ignored.
- WHO_AM_I_VAL, 8'h68: value returned at register 0x75.
- HOLD_CYCLES, 4: clk_in cycles after a detected SCL fall before SDA drive changes; legal range 1..15.
- clk_in  input  1  system clock; must be at least 20× SCL frequency.
- rst_n_in  input  1  reset; asynchronous, active-low.
- scl_in  input  1  raw SCL pin level, asynchronous.
- sda_in  input  1  raw SDA pin level, asynchronous.
- sda_oe_out  output  1  1 = pull SDA low; 0 = release (the pad is open-drain).
- gx_in, gy_in, gz_in  input  16 each  signed gyro samples, two's complement.
- pwr_mgmt_out  output  8  current PWR_MGMT_1 register (0x6B).
- wr_strobe_out  output  1  one-cycle pulse when any register byte is written.
- busy_out  output  1  high from an addressed START (ACKed address) until STOP.

## Operation
- Front end: 2-flop synchronizer on SCL/SDA, then edge detect. START = SDA fall while SCL high. STOP = SDA rise while SCL high.
- Data is sampled on the synchronized SCL rise. Bytes are MSB first. A 3-bit bit counter runs 7→0.
- States:
  - IDLE
  - ADDR: shift 8 bits.
  - ADDR_ACK: drive ACK if the address matches, else return to IDLE and release SDA.
  - WR_PTR: first write byte loads the pointer.
  - WR_DATA
  - WR_ACK
  - RD_DATA
  - RD_MACK: sample the master's ACK/NACK.
- START in any state goes to ADDR (repeated start); the pointer is kept. STOP in any state goes to IDLE, releases SDA and clears busy.
- Write path: each byte after the pointer byte writes reg[ptr], pulses wr_strobe_out, then ptr increments. Only 0x6B is writable; writes to other addresses are ACKed and discarded.
- Read path: when the address byte with R/W=1 is ACKed, gx/gy/gz are snapshotted into 6 bytes, held atomic for the whole transaction. The target sends reg[ptr] and ptr++ after each byte. A master ACK loads the next byte; a NACK goes to IDLE-wait (SDA released until STOP/START).
- Register map (unlisted addresses read 0x00):
  - 0x43/0x44 = gx hi/lo
  - 0x45/0x46 = gy hi/lo
  - 0x47/0x48 = gz hi/lo
  - 0x6B = PWR_MGMT_1
  - 0x75 = WHO_AM_I_VAL
- Pointer is 8 bits and wraps 0xFF→0x00.

## Timing
- Reset values: sda_oe_out=0, pwr_mgmt_out=8'h40, wr_strobe_out=0, busy_out=0; state IDLE, ptr=0x00.
- Pin-to-internal latency: 2 cycles (synchronizer) plus 1 cycle (edge register).
- SDA drive (ACK or data bit) changes exactly HOLD_CYCLES cycles after the internal SCL-fall event, never while SCL is high. ACK is released HOLD_CYCLES cycles after the 9th SCL fall.
- wr_strobe_out pulses the cycle after the 8th data-bit SCL rise. pwr_mgmt_out updates in the same cycle.
- Snapshot is taken on the cycle the address match is decided.
- The block never stretches SCL.
- Reset asserted mid-transfer releases SDA immediately, without waiting for a clock.
- START and STOP cannot both occur in the same cycle. If SCL and SDA edges land in the same cycle, the SCL edge is processed first.

## Configuration
- MPU_TARGET_GLITCH_FILTER_EN
  - Defined: a 3-sample majority filter follows each synchronizer. This adds 2 cycles of latency, and pulses of 1 cycle or less are rejected.
  - Undefined: no filter; latency is as stated in Timing.

## Structure
- mpu_target_pkg:
  - state enum
  - register address constants: REG_GYRO_XH=0x43 … REG_GYRO_ZL=0x48, REG_PWR_MGMT_1=0x6B, REG_WHO_AM_I=0x75
  - PWR_MGMT_1 reset constant 8'h40
- Sub-module i2c_line_sync: synchronizer, optional filter, and edge/START/STOP detect. Outputs scl_rise, scl_fall, start, stop and filtered sda.

## Test plan
- Write 0xD0, 0x6B, 0x00 → three ACKs (sda_oe_out=1 on each 9th bit), one wr_strobe_out pulse, pwr_mgmt_out=0x00.
- Write 0xD0, 0x75, repeated START, read 0xD1, one byte with NACK → byte 0x68 on the bus, busy_out low after STOP.
- gx=0x1234, gy=0x8001, gz=0xFFFF; ptr=0x43; burst-read 6 bytes, changing gx_in mid-burst → 12 34 80 01 FF FF.
- Address 0xA0 → no ACK (sda_oe_out stays 0), state IDLE, busy_out stays 0.
- ptr=0xFF, read 2 bytes → 0x00 then 0x00 (wrap to 0x00), no hang.
- Drop rst_n_in while the target is driving a 0 data bit → sda_oe_out=0 within the same cycle. After release, a clean transaction succeeds.
